// File: rtl/stand_dff.sv
// ---------------------------------------------------------------------------
// stand_dff
//
// Cycle-counted behavioural model of one discrete-transistor D flip-flop for
// the DE0 FPGA build of the processor. It sits downstream of the standard-cell
// inverter model, so T, D, _PS and _PC are already synchronous to U. Every
// delay is counted in cycles of the fast model clock U.
//
// Parameters
//   TCQ  clock-to-Q delay in U cycles, 1..31
//   TSU  setup window in U cycles, 0..31
//   THD  hold window in U cycles, 0..31
//
// Ports
//   U      in   fast model clock
//   RESET  in   synchronous, active-high reset
//   T      in   modelled flip-flop clock, captures on a rising edge
//   D      in   data
//   _PS    in   active-low preset
//   _PC    in   active-low clear
//   Q      out  true output
//   _Q     out  complementary output (also high in the both-low override)
//   VIOL   out  sticky setup/hold violation flag
//
// Optional feature
//   STAND_DFF_TIMING_CHECK_EN  when defined, the setup/hold checker is built
//                              and drives VIOL; when undefined VIOL is tied
//                              low. Capture, delay and override behave the
//                              same either way.
// ---------------------------------------------------------------------------
module stand_dff #(
    parameter int TCQ = 6,
    parameter int TSU = 4,
    parameter int THD = 2
) (
    input  logic U,
    input  logic RESET,
    input  logic T,
    input  logic D,
    input  logic _PS,
    input  logic _PC,
    output logic Q,
    output logic _Q,
    output logic VIOL
);

    localparam logic IDLE  = 1'b0;
    localparam logic DELAY = 1'b1;

    // Counter reload value: an edge at posedge k loads TCQ-1 so that the
    // output changes exactly at posedge k+TCQ (TCQ=1 -> the very next edge).
    localparam logic [4:0] DCNT_LOAD = 5'(TCQ - 1);

    logic       state;
    logic       t_prev;
    logic       cap;
    logic [4:0] dcnt;

    logic       rise;
    logic       override;

    assign rise     = T & ~t_prev;
    assign override = ~_PS | ~_PC;

    // -----------------------------------------------------------------------
    // Capture, clock-to-Q delay and preset/clear override
    // -----------------------------------------------------------------------
    // NOTE: reset is sampled inside the clocked block, so it is synchronous;
    // every register here is a plain flop and takes its value with <=.
    always_ff @(posedge U) begin
        if (RESET) begin
            Q      <= 1'b0;
            _Q     <= 1'b1;
            state  <= IDLE;
            t_prev <= 1'b1;
            cap    <= 1'b0;
            dcnt   <= '0;
        end else begin
            t_prev <= T;

            if (override) begin
                // Override wins over everything: drop any pending capture
                // and ignore T edges while either pin is low.
                case ({_PS, _PC})
                    2'b01: begin
                        Q  <= 1'b1;
                        _Q <= 1'b0;
                    end
                    2'b10: begin
                        Q  <= 1'b0;
                        _Q <= 1'b1;
                    end
                    default: begin
                        Q  <= 1'b1;
                        _Q <= 1'b1;
                    end
                endcase
                state <= IDLE;
            end else begin
                // Leaving the both-low override: Q stays 1, _Q falls back to
                // the complement. This is the only way Q can equal _Q.
                if (Q == _Q) begin
                    _Q <= ~Q;
                end

                if (rise) begin
                    // A new edge (IDLE or DELAY) reloads the capture; any
                    // value still in flight is discarded.
                    cap   <= D;
                    dcnt  <= DCNT_LOAD;
                    state <= DELAY;
                end else if (state == DELAY) begin
                    if (dcnt == 5'd0) begin
                        Q     <= cap;
                        _Q    <= ~cap;
                        state <= IDLE;
                    end else begin
                        dcnt <= dcnt - 5'd1;
                    end
                end
            end
        end
    end

`ifdef STAND_DFF_TIMING_CHECK_EN
    // -----------------------------------------------------------------------
    // Setup/hold checker
    // -----------------------------------------------------------------------
    localparam logic [4:0] TSU_L = 5'(TSU);
    localparam logic [4:0] THD_L = 5'(THD);

    logic       d_prev;
    logic [4:0] scnt;   // cycles D has been stable, saturating at 31
    logic [4:0] hcnt;   // remaining hold-window posedges after an edge
    logic       det;    // violation seen at this posedge, flagged next one

    logic       setup_v;
    logic       hold_v;

    // Setup uses SCNT before its update at the edge; only edges that are
    // actually accepted (no override) are checked.
    assign setup_v = rise & ~override & (scnt < TSU_L);
    // Hold window covers posedges k+1..k+THD after the edge at k.
    assign hold_v  = (hcnt != 5'd0) & (D != cap);

    always_ff @(posedge U) begin
        if (RESET) begin
            d_prev <= D;
            scnt   <= 5'd31;
            hcnt   <= 5'd0;
            det    <= 1'b0;
            VIOL   <= 1'b0;
        end else begin
            d_prev <= D;

            if (D != d_prev) begin
                scnt <= 5'd0;
            end else if (scnt != 5'd31) begin
                scnt <= scnt + 5'd1;
            end

            // The override drops the capture, so the hold window goes too.
            if (override) begin
                hcnt <= 5'd0;
            end else if (rise) begin
                hcnt <= THD_L;
            end else if (hcnt != 5'd0) begin
                hcnt <= hcnt - 5'd1;
            end

            det <= setup_v | hold_v;
            if (det) begin
                VIOL <= 1'b1;
            end
        end
    end
`else
    // Checker not built: the timing parameters only feed this sink.
    logic unused_timing_cfg;
    assign unused_timing_cfg = ^{TSU[4:0], THD[4:0]};

    assign VIOL = 1'b0;
`endif

endmodule

// File: tb/tb_stand_dff.sv
// ---------------------------------------------------------------------------
// tb_stand_dff
//
// Bench for stand_dff with TCQ=6, TSU=4, THD=2. Directed table, hand-written
// multi-cycle sequences and a randomized run against a time-stamp reference
// model. Expected VIOL depends on whether STAND_DFF_TIMING_CHECK_EN is set.
// ---------------------------------------------------------------------------
module tb_stand_dff;

    localparam int TCQ = 6;
    localparam int TSU = 4;
    localparam int THD = 2;
`ifdef STAND_DFF_TIMING_CHECK_EN
    localparam bit TC = 1'b1;
`else
    localparam bit TC = 1'b0;
`endif
    localparam int NEVER = -1000000;

    logic u;
    logic rst, t, d, ps_n, pc_n;
    logic q, q_n, viol;

    int n_pass;
    int n_total;

    stand_dff #(.TCQ(TCQ), .TSU(TSU), .THD(THD)) dut (
        .U    (u),
        .RESET(rst),
        .T    (t),
        .D    (d),
        ._PS  (ps_n),
        ._PC  (pc_n),
        .Q    (q),
        ._Q   (q_n),
        .VIOL (viol)
    );

    initial u = 1'b0;
    always #5 u = ~u;

    // -----------------------------------------------------------------------
    // Reference model: absolute time stamps instead of counters.
    //   m_due    cycle at which the pending capture reaches Q (NEVER = none)
    //   m_edge_t cycle of the last accepted edge (hold window anchor)
    //   m_lc     cycle at which D was last seen to change
    // -----------------------------------------------------------------------
    int cyc;
    bit m_q, m_nq, m_viol, m_det, m_tprev, m_dprev, m_cap;
    int m_due, m_edge_t, m_lc;

    task automatic model_step(input bit r, input bit tt, input bit dd,
                              input bit ps, input bit pc);
        bit sv;
        bit hv;
        bit rise_s;
        cyc++;
        if (r) begin
            m_q = 1'b0; m_nq = 1'b1; m_viol = 1'b0; m_det = 1'b0;
            m_tprev = 1'b1; m_dprev = dd;
            m_lc = NEVER; m_due = NEVER; m_edge_t = NEVER;
        end else begin
            sv = 1'b0;
            hv = (cyc > m_edge_t) && (cyc <= m_edge_t + THD) && (dd != m_cap);
            m_viol = m_viol | m_det;
            rise_s = tt && !m_tprev;
            if (!ps || !pc) begin
                m_q  = !ps;
                m_nq = !pc;
                m_due = NEVER;
                m_edge_t = NEVER;
            end else begin
                if (m_q == m_nq) m_nq = !m_q;
                if (rise_s) begin
                    sv = ((cyc - 1 - m_lc) < TSU);
                    m_cap = dd;
                    m_due = cyc + TCQ;
                    m_edge_t = cyc;
                end else if (cyc == m_due) begin
                    m_q = m_cap;
                    m_nq = !m_cap;
                    m_due = NEVER;
                end
            end
            m_det = sv | hv;
            if (dd != m_dprev) m_lc = cyc;
            m_dprev = dd;
            m_tprev = tt;
        end
    endtask

    // Drive one cycle of inputs, let the posedge sample them, then settle.
    task automatic step(input bit r, input bit tt, input bit dd,
                        input bit ps, input bit pc);
        rst = r; t = tt; d = dd; ps_n = ps; pc_n = pc;
        @(posedge u);
        model_step(r, tt, dd, ps, pc);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic exp_v);
        n_total++;
        if (act !== exp_v) begin
            $display("FAIL %s (cycle %0d): got %b expected %b", name, cyc, act, exp_v);
        end else begin
            n_pass++;
        end
    endtask

    typedef struct packed {
        bit r, tt, dd, ps, pc;
        bit eq, enq, ev;
    } vec_t;

    vec_t tbl [14];

    initial begin
        bit rt, rd, rr, rps, rpc;
        n_pass = 0; n_total = 0; cyc = 0;
        rst = 1'b1; t = 1'b0; d = 1'b0; ps_n = 1'b1; pc_n = 1'b1;

        // ---------------- table: reset and override combinations ----------
        //             r  t  d  ps pc  q  nq v
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0};
        tbl[1]  = '{1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0};
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0};
        tbl[10] = '{1'b0,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0};
        tbl[11] = '{1'b0,1'b1,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0};
        tbl[13] = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].r, tbl[i].tt, tbl[i].dd, tbl[i].ps, tbl[i].pc);
            check($sformatf("tbl%0d_q", i), q, tbl[i].eq);
            check($sformatf("tbl%0d_qn", i), q_n, tbl[i].enq);
            check($sformatf("tbl%0d_viol", i), viol, tbl[i].ev);
        end

        // ---------------- A: basic clock-to-Q ------------------------------
        step(1, 0, 1, 1, 1);
        check("a_reset_q", q, 1'b0);
        check("a_reset_qn", q_n, 1'b1);
        repeat (9) step(0, 0, 1, 1, 1);
        step(0, 1, 1, 1, 1);                       // edge at k
        check("a_q_k", q, 1'b0);
        for (int j = 1; j < TCQ; j++) begin
            step(0, (j < 3), 1, 1, 1);
            check($sformatf("a_q_k%0d", j), q, 1'b0);
        end
        step(0, 0, 1, 1, 1);                       // k+TCQ
        check("a_q_tcq", q, 1'b1);
        check("a_qn_tcq", q_n, 1'b0);
        check("a_viol", viol, 1'b0);

        // ---------------- B: retrigger discards pending value -------------
        step(1, 0, 1, 1, 1);
        repeat (6) step(0, 0, 1, 1, 1);
        step(0, 1, 1, 1, 1);                       // k, captures 1
        step(0, 0, 0, 1, 1);                       // k+1, D changes
        check("b_viol_k1", viol, 1'b0);
        step(0, 0, 0, 1, 1);                       // k+2
        step(0, 1, 0, 1, 1);                       // k+3, captures 0
        check("b_q_k3", q, 1'b0);
        for (int j = 4; j <= 12; j++) begin
            step(0, 0, 0, 1, 1);
            check($sformatf("b_q_k%0d", j), q, 1'b0);
            check($sformatf("b_qn_k%0d", j), q_n, 1'b1);
        end
        check("b_viol", viol, TC);

        // ---------------- C: clear during DELAY ----------------------------
        step(1, 0, 1, 1, 1);
        step(0, 0, 1, 0, 1);
        check("c_preset_q", q, 1'b1);
        check("c_preset_qn", q_n, 1'b0);
        step(0, 0, 1, 1, 1);
        check("c_release_q", q, 1'b1);
        check("c_release_qn", q_n, 1'b0);
        repeat (3) step(0, 0, 1, 1, 1);
        step(0, 1, 1, 1, 1);                       // k, pending 1
        step(0, 0, 1, 1, 1);                       // k+1
        step(0, 0, 1, 1, 0);                       // m = k+2
        check("c_clear_q", q, 1'b0);
        check("c_clear_qn", q_n, 1'b1);
        for (int j = 3; j <= 7; j++) begin
            step(0, j[0], 1, 1, 0);                // T edges while cleared
            check($sformatf("c_hold_q_k%0d", j), q, 1'b0);
        end
        step(0, 1, 1, 1, 1);                       // release, T stays high
        check("c_rel_q", q, 1'b0);
        check("c_rel_qn", q_n, 1'b1);
        for (int j = 0; j < 7; j++) begin
            step(0, 0, 1, 1, 1);
            check($sformatf("c_after_q%0d", j), q, 1'b0);
        end
        check("c_viol", viol, 1'b0);

        // ---------------- D: setup window boundaries -----------------------
        for (int lead = 2; lead <= 5; lead++) begin
            step(1, 0, 0, 1, 1);
            repeat (4) step(0, 0, 0, 1, 1);
            repeat (lead) step(0, 0, 1, 1, 1);     // D changed lead cycles early
            step(0, 1, 1, 1, 1);                   // edge
            check($sformatf("d_lead%0d_k", lead), viol, 1'b0);
            step(0, 0, 1, 1, 1);
            check($sformatf("d_lead%0d_k1", lead), viol, TC & (lead <= TSU));
            step(0, 0, 1, 1, 1);
            check($sformatf("d_lead%0d_k2", lead), viol, TC & (lead <= TSU));
        end

        // ---------------- E: hold window boundaries -----------------------
        for (int h = 1; h <= 3; h++) begin
            step(1, 0, 0, 1, 1);
            step(0, 0, 0, 1, 1);
            step(0, 1, 0, 1, 1);                   // edge two cycles after reset
            for (int j = 1; j < h; j++) step(0, 1, 0, 1, 1);
            step(0, 0, 1, 1, 1);                   // D toggles at k+h
            check($sformatf("e_h%0d_kh", h), viol, 1'b0);
            step(0, 0, 1, 1, 1);
            check($sformatf("e_h%0d_kh1", h), viol, TC & (h <= THD));
            step(0, 0, 1, 1, 1);
            check($sformatf("e_h%0d_kh2", h), viol, TC & (h <= THD));
        end

        // ---------------- F: reset during DELAY ----------------------------
        step(1, 0, 0, 1, 1);
        repeat (5) step(0, 0, 0, 1, 1);
        step(0, 0, 1, 1, 1);                       // k-1, D changes
        step(0, 1, 1, 1, 1);                       // k, setup violation
        step(0, 0, 1, 1, 1);                       // k+1
        check("f_viol_k1", viol, TC);
        step(1, 0, 1, 1, 1);                       // k+2, reset
        check("f_rst_q", q, 1'b0);
        check("f_rst_qn", q_n, 1'b1);
        check("f_rst_viol", viol, 1'b0);
        for (int j = 3; j <= 8; j++) begin
            step(0, 0, 1, 1, 1);
            check($sformatf("f_q_k%0d", j), q, 1'b0);
        end

        // ---------------- random run against the model -------------------
        rt = 1'b0; rd = 1'b0;
        step(1, 0, 0, 1, 1);
        for (int i = 0; i < 4000; i++) begin
            rr  = ($urandom_range(0, 149) == 0);
            rps = ($urandom_range(0, 24) != 0);
            rpc = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 5) == 0) rt = ~rt;
            if (i < 2000) begin
                if ($urandom_range(0, 39) == 0) rd = ~rd;
            end else begin
                if ($urandom_range(0, 6) == 0) rd = ~rd;
            end
            step(rr, rt, rd, rps, rpc);
            check("rand_q", q, m_q);
            check("rand_qn", q_n, m_nq);
            check("rand_viol", viol, TC & m_viol);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
